// File: rtl/commit_tracker_pkg.sv
// Shared types, default configuration and helpers for the in-order commit tracker.
// The optional writeback bypass (COMMIT_TRACKER_WB_BYPASS_EN) is handled in commit_tracker.sv.
package commit_tracker_pkg;

    // Ceiling log2 usable in parameter expressions; returns 0 for values 0 and 1.
    function automatic int unsigned ct_clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 32'd0;
        span   = 32'd1;
        while (span < value) begin
            span   = span << 32'd1;
            result = result + 32'd1;
        end
        return result;
    endfunction

    // Defaults follow the CVA6 commit-port and scoreboard sizing.
    localparam int unsigned CVA6_NR_COMMIT_PORTS  = 32'd2;
    localparam int unsigned CVA6_NR_SB_ENTRIES    = 32'd8;
    localparam int unsigned DEFAULT_NR_WB_PORTS   = 32'd4;
    localparam int unsigned DEFAULT_PAYLOAD_W     = 32'd64;
    localparam int unsigned DEFAULT_TRANS_ID_BITS = ct_clog2(CVA6_NR_SB_ENTRIES);

    // Pointer carries one extra wrap bit above the entry index.
    typedef logic [DEFAULT_TRANS_ID_BITS:0] ptr_t;

    typedef struct packed {
        logic                         valid;
        logic                         done;
        logic [DEFAULT_PAYLOAD_W-1:0] payload;
    } entry_t;

endpackage

// File: rtl/commit_prefix_count.sv
// Counts the length of the contiguous run of set bits starting at bit 0.
// Used to turn per-port ack&&valid into the number of entries retired in order.
module commit_prefix_count
    import commit_tracker_pkg::*;
#(
    parameter int unsigned NR_PORTS = CVA6_NR_COMMIT_PORTS,
    parameter int unsigned CNT_W    = ct_clog2(NR_PORTS + 32'd1)
) (
    input  logic [NR_PORTS-1:0] hit_i,
    output logic [CNT_W-1:0]    count_o
);

    // A port only counts while every lower port also hit.
    always_comb begin
        logic run_v;
        count_o = '0;
        run_v   = 1'b1;
        for (int k = 0; k < int'(NR_PORTS); k++) begin
            run_v   = run_v & hit_i[k];
            count_o = count_o + CNT_W'(run_v);
        end
    end

endmodule

// File: rtl/commit_tracker.sv
// In-order commit tracker: circular buffer that allocates at issue, marks done on
// writeback and retires an oldest-first prefix. Define COMMIT_TRACKER_WB_BYPASS_EN
// to make writebacks commit-eligible in the same cycle.
module commit_tracker
    import commit_tracker_pkg::*;
#(
    parameter int unsigned NR_ENTRIES      = CVA6_NR_SB_ENTRIES,
    parameter int unsigned NR_COMMIT_PORTS = CVA6_NR_COMMIT_PORTS,
    parameter int unsigned NR_WB_PORTS     = DEFAULT_NR_WB_PORTS,
    parameter int unsigned PAYLOAD_W       = DEFAULT_PAYLOAD_W,
    parameter int unsigned TRANS_ID_BITS   = ct_clog2(NR_ENTRIES)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     flush_i,
    input  logic                                     issue_valid_i,
    input  logic [PAYLOAD_W-1:0]                     issue_payload_i,
    output logic                                     issue_ready_o,
    output logic [TRANS_ID_BITS-1:0]                 issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                   wb_valid_i,
    input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0]     wb_trans_id_i,
    output logic [NR_COMMIT_PORTS-1:0]               commit_valid_o,
    output logic [NR_COMMIT_PORTS*PAYLOAD_W-1:0]     commit_payload_o,
    output logic [NR_COMMIT_PORTS*TRANS_ID_BITS-1:0] commit_trans_id_o,
    input  logic [NR_COMMIT_PORTS-1:0]               commit_ack_i,
    output logic [TRANS_ID_BITS:0]                   usage_o
);

    localparam int unsigned CNT_W = ct_clog2(NR_COMMIT_PORTS + 32'd1);

    typedef logic [TRANS_ID_BITS:0] tracker_ptr_t;

    tracker_ptr_t               head_r;
    tracker_ptr_t               tail_r;
    tracker_ptr_t               usage_s;
    logic [NR_ENTRIES-1:0]      valid_r;
    logic [NR_ENTRIES-1:0]      done_r;
    logic [NR_ENTRIES-1:0]      valid_nx_s;
    logic [NR_ENTRIES-1:0]      done_nx_s;
    logic [NR_ENTRIES-1:0]      wb_set_s;
    logic [NR_ENTRIES-1:0]      done_eff_s;
    logic [PAYLOAD_W-1:0]       payload_r [NR_ENTRIES];
    logic [TRANS_ID_BITS-1:0]   head_idx_s;
    logic [TRANS_ID_BITS-1:0]   tail_idx_s;
    logic [TRANS_ID_BITS-1:0]   port_idx_s [NR_COMMIT_PORTS];
    logic [NR_COMMIT_PORTS-1:0] commit_valid_s;
    logic [NR_COMMIT_PORTS-1:0] retire_hit_s;
    logic [CNT_W-1:0]           retire_cnt_s;
    logic                       issue_ready_s;
    logic                       issue_fire_s;

    // Occupancy falls out of the wrap-bit pointers, so issue status is registered-state only.
    assign usage_s       = tail_r - head_r;
    assign head_idx_s    = head_r[TRANS_ID_BITS-1:0];
    assign tail_idx_s    = tail_r[TRANS_ID_BITS-1:0];
    assign issue_ready_s = (usage_s < tracker_ptr_t'(NR_ENTRIES));
    assign issue_fire_s  = issue_valid_i & issue_ready_s;

    // Decode all writeback ports into a per-entry set mask; duplicates simply merge.
    always_comb begin
        wb_set_s = '0;
        for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
            for (int e = 0; e < int'(NR_ENTRIES); e++) begin
                wb_set_s[e] = wb_set_s[e]
                            | (wb_valid_i[p]
                               & (wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS] == TRANS_ID_BITS'(e)));
            end
        end
    end

`ifdef COMMIT_TRACKER_WB_BYPASS_EN
    assign done_eff_s = done_r | (wb_set_s & valid_r);
`else
    assign done_eff_s = done_r;
`endif

    // Present head..head+NR_COMMIT_PORTS-1; a port is valid only if all older ports are.
    always_comb begin
        logic run_v;
        commit_valid_s = '0;
        run_v          = 1'b1;
        for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
            port_idx_s[k]     = head_idx_s + TRANS_ID_BITS'(k);
            run_v             = run_v & valid_r[port_idx_s[k]] & done_eff_s[port_idx_s[k]];
            commit_valid_s[k] = run_v;
        end
    end

    for (genvar k = 0; k < int'(NR_COMMIT_PORTS); k++) begin : g_commit_port
        assign commit_payload_o[k*PAYLOAD_W +: PAYLOAD_W]          = payload_r[port_idx_s[k]];
        assign commit_trans_id_o[k*TRANS_ID_BITS +: TRANS_ID_BITS] = port_idx_s[k];
    end

    assign retire_hit_s = commit_ack_i & commit_valid_s;

    commit_prefix_count #(
        .NR_PORTS (NR_COMMIT_PORTS),
        .CNT_W    (CNT_W)
    ) u_prefix (
        .hit_i   (retire_hit_s),
        .count_o (retire_cnt_s)
    );

    // Next entry status: writeback, then retirement, then allocation at the tail.
    always_comb begin
        valid_nx_s = valid_r;
        done_nx_s  = done_r | (wb_set_s & valid_r);
        for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
            valid_nx_s[port_idx_s[k]] = valid_nx_s[port_idx_s[k]] & (CNT_W'(k) >= retire_cnt_s);
            done_nx_s[port_idx_s[k]]  = done_nx_s[port_idx_s[k]] & (CNT_W'(k) >= retire_cnt_s);
        end
        valid_nx_s[tail_idx_s] = valid_nx_s[tail_idx_s] | issue_fire_s;
        done_nx_s[tail_idx_s]  = done_nx_s[tail_idx_s] & ~issue_fire_s;
    end

    // Pointer and status state; flush overrides every other request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_r  <= '0;
            tail_r  <= '0;
            valid_r <= '0;
            done_r  <= '0;
        end else if (flush_i) begin
            head_r  <= '0;
            tail_r  <= '0;
            valid_r <= '0;
            done_r  <= '0;
        end else begin
            head_r  <= head_r + tracker_ptr_t'(retire_cnt_s);
            tail_r  <= tail_r + tracker_ptr_t'(issue_fire_s);
            valid_r <= valid_nx_s;
            done_r  <= done_nx_s;
        end
    end

    // Payload storage is written at allocation and carries no reset.
    always_ff @(posedge clk_i) begin
        if (issue_fire_s && !flush_i) begin
            payload_r[tail_idx_s] <= issue_payload_i;
        end
    end

    assign issue_ready_o    = issue_ready_s;
    assign issue_trans_id_o = tail_idx_s;
    assign usage_o          = usage_s;
    assign commit_valid_o   = commit_valid_s;

endmodule

// File: tb/tb_commit_tracker.sv
// Self-checking bench for commit_tracker: directed scenarios plus random traffic
// compared every cycle against an occupancy/queue model of the buffer.
module tb_commit_tracker;

    localparam int N  = 8;
    localparam int C  = 2;
    localparam int W  = 4;
    localparam int PW = 64;
    localparam int TB = 3;

    logic              clk_s = 1'b0;
    logic              rst_n_s = 1'b0;
    logic              flush_s = 1'b0;
    logic              issue_valid_s = 1'b0;
    logic [PW-1:0]     issue_payload_s = '0;
    logic              issue_ready_s;
    logic [TB-1:0]     issue_trans_id_s;
    logic [W-1:0]      wb_valid_s = '0;
    logic [W*TB-1:0]   wb_trans_id_s = '0;
    logic [C-1:0]      commit_valid_s;
    logic [C*PW-1:0]   commit_payload_s;
    logic [C*TB-1:0]   commit_trans_id_s;
    logic [C-1:0]      commit_ack_s = '0;
    logic [TB:0]       usage_s;

    int checks = 0;
    int failures = 0;

    // Model: oldest entry index, occupancy, per-slot done flag and payload.
    int            mhead = 0;
    int            mcount = 0;
    bit            mdone [N];
    logic [PW-1:0] mpay [N];

    always #5 clk_s = ~clk_s;

    commit_tracker dut (
        .clk_i             (clk_s),
        .rst_ni            (rst_n_s),
        .flush_i           (flush_s),
        .issue_valid_i     (issue_valid_s),
        .issue_payload_i   (issue_payload_s),
        .issue_ready_o     (issue_ready_s),
        .issue_trans_id_o  (issue_trans_id_s),
        .wb_valid_i        (wb_valid_s),
        .wb_trans_id_i     (wb_trans_id_s),
        .commit_valid_o    (commit_valid_s),
        .commit_payload_o  (commit_payload_s),
        .commit_trans_id_o (commit_trans_id_s),
        .commit_ack_i      (commit_ack_s),
        .usage_o           (usage_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit eff_done(input int i);
        bit d;
        d = mdone[i];
`ifdef COMMIT_TRACKER_WB_BYPASS_EN
        for (int p = 0; p < W; p++) begin
            if (wb_valid_s[p] && int'(wb_trans_id_s[p*TB +: TB]) == i) d = 1'b1;
        end
`endif
        return d;
    endfunction

    function automatic logic [C-1:0] exp_cv();
        logic [C-1:0] v;
        bit run;
        v = '0;
        run = 1'b1;
        for (int k = 0; k < C; k++) begin
            run = run && (k < mcount) && eff_done((mhead + k) % N);
            v[k] = run;
        end
        return v;
    endfunction

    task automatic compare_all();
        logic [C-1:0] cv;
        cv = exp_cv();
        chk("issue_ready", 64'(issue_ready_s), 64'(mcount < N));
        chk("issue_trans_id", 64'(issue_trans_id_s), 64'((mhead + mcount) % N));
        chk("usage", 64'(usage_s), 64'(mcount));
        chk("commit_valid", 64'(commit_valid_s), 64'(cv));
        for (int k = 0; k < C; k++) begin
            chk("commit_trans_id", 64'(commit_trans_id_s[k*TB +: TB]), 64'((mhead + k) % N));
            if (cv[k]) chk("commit_payload", commit_payload_s[k*PW +: PW], mpay[(mhead + k) % N]);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [C-1:0] cv;
        int n;
        bit run;
        int tail;
        bit accept;
        int id;
        cv = exp_cv();
        if (flush_s) begin
            mhead = 0;
            mcount = 0;
            for (int i = 0; i < N; i++) mdone[i] = 1'b0;
        end else begin
            n = 0;
            run = 1'b1;
            for (int k = 0; k < C; k++) begin
                run = run && cv[k] && commit_ack_s[k];
                if (run) n++;
            end
            accept = issue_valid_s && (mcount < N);
            tail = (mhead + mcount) % N;
            for (int p = 0; p < W; p++) begin
                id = int'(wb_trans_id_s[p*TB +: TB]);
                if (wb_valid_s[p] && ((id - mhead + N) % N) < mcount) mdone[id] = 1'b1;
            end
            for (int k = 0; k < n; k++) mdone[(mhead + k) % N] = 1'b0;
            mhead = (mhead + n) % N;
            mcount = mcount - n;
            if (accept) begin
                mdone[tail] = 1'b0;
                mpay[tail] = issue_payload_s;
                mcount++;
            end
        end
    endtask

    task automatic step(input bit f, input bit v, input logic [PW-1:0] pay,
                        input logic [W-1:0] wbv, input logic [W*TB-1:0] wbid, input logic [C-1:0] ack);
        @(negedge clk_s);
        flush_s = f;
        issue_valid_s = v;
        issue_payload_s = pay;
        wb_valid_s = wbv;
        wb_trans_id_s = wbid;
        commit_ack_s = ack;
        #1;
        compare_all();
        model_step();
        @(posedge clk_s);
        #2;
    endtask

    function automatic logic [W*TB-1:0] ids(input int a, input int b);
        logic [W*TB-1:0] r;
        r = '0;
        r[0 +: TB] = TB'(a);
        r[TB +: TB] = TB'(b);
        return r;
    endfunction

    function automatic logic [PW-1:0] rpay();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [W-1:0] wbv;
        logic [W*TB-1:0] wbid;
        for (int i = 0; i < N; i++) begin
            mdone[i] = 1'b0;
            mpay[i] = '0;
        end
        repeat (3) @(posedge clk_s);
        @(negedge clk_s);
        rst_n_s = 1'b1;
        #1;
        chk("lit_reset_usage", 64'(usage_s), 64'd0);
        chk("lit_reset_ready", 64'(issue_ready_s), 64'd1);
        chk("lit_reset_id", 64'(issue_trans_id_s), 64'd0);
        chk("lit_reset_cv", 64'(commit_valid_s), 64'd0);

        // Fill the buffer back-to-back, then try a ninth issue.
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b1, rpay(), '0, '0, '0);
        end
        chk("lit_full_usage", 64'(usage_s), 64'd8);
        chk("lit_full_ready", 64'(issue_ready_s), 64'd0);
        step(1'b0, 1'b1, rpay(), '0, '0, '0);
        chk("lit_ninth_rejected", 64'(usage_s), 64'd8);

        // Writeback 1 and 0 together, then retire both.
        step(1'b0, 1'b0, '0, 4'b0011, ids(1, 0), '0);
        chk("lit_wb_cv", 64'(commit_valid_s), 64'd3);
        step(1'b0, 1'b0, '0, '0, '0, 2'b11);
        chk("lit_retire2_usage", 64'(usage_s), 64'd6);
        chk("lit_retire2_head", 64'(commit_trans_id_s[0 +: TB]), 64'd2);
        chk("lit_retire2_cv", 64'(commit_valid_s), 64'd0);

        // Younger done, oldest pending; then a lone port-1 ack.
        step(1'b0, 1'b0, '0, 4'b0001, ids(3, 0), '0);
        chk("lit_pending_head_cv", 64'(commit_valid_s), 64'd0);
        step(1'b0, 1'b0, '0, 4'b0001, ids(2, 0), '0);
        chk("lit_both_done_cv", 64'(commit_valid_s), 64'd3);
        step(1'b0, 1'b0, '0, '0, '0, 2'b10);
        chk("lit_port1_only", 64'(usage_s), 64'd6);
        step(1'b0, 1'b0, '0, '0, '0, 2'b11);
        chk("lit_retire_usage4", 64'(usage_s), 64'd4);

        // Refill to full, then commit two while an issue is presented.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rpay(), '0, '0, '0);
        chk("lit_refull_ready", 64'(issue_ready_s), 64'd0);
        step(1'b0, 1'b0, '0, 4'b0011, ids(4, 5), '0);
        chk("lit_refull_cv", 64'(commit_valid_s), 64'd3);
        step(1'b0, 1'b1, rpay(), '0, '0, 2'b11);
        chk("lit_full_commit_usage", 64'(usage_s), 64'd6);
        chk("lit_full_commit_ready", 64'(issue_ready_s), 64'd1);
        chk("lit_full_commit_id", 64'(issue_trans_id_s), 64'd4);
        step(1'b0, 1'b1, rpay(), '0, '0, '0);
        chk("lit_after_issue_usage", 64'(usage_s), 64'd7);

        // Flush against simultaneous issue, writeback and ack, held for two cycles.
        step(1'b0, 1'b0, '0, 4'b0011, ids(6, 7), '0);
        step(1'b1, 1'b1, rpay(), 4'b0011, ids(0, 1), 2'b11);
        chk("lit_flush_usage", 64'(usage_s), 64'd0);
        chk("lit_flush_cv", 64'(commit_valid_s), 64'd0);
        chk("lit_flush_id", 64'(issue_trans_id_s), 64'd0);
        chk("lit_flush_ready", 64'(issue_ready_s), 64'd1);
        step(1'b1, 1'b1, rpay(), '0, '0, '0);
        chk("lit_flush_hold", 64'(usage_s), 64'd0);

        // Steady-state streaming across the index wrap.
        for (int i = 0; i < 16; i++) begin
            if (mcount > 0) step(1'b0, 1'b1, rpay(), 4'b0001, ids((mhead + mcount - 1) % N, 0), 2'b11);
            else step(1'b0, 1'b1, rpay(), '0, '0, 2'b11);
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            wbv = '0;
            wbid = '0;
            for (int p = 0; p < W; p++) begin
                wbv[p] = ($urandom_range(0, 9) < 3);
                if ($urandom_range(0, 1) == 0 && mcount > 0)
                    wbid[p*TB +: TB] = TB'((mhead + $urandom_range(0, mcount - 1)) % N);
                else
                    wbid[p*TB +: TB] = TB'($urandom_range(0, N - 1));
            end
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7), rpay(),
                 wbv, wbid, C'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
